mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of all address ports.
REQ-002 Parameter DW, default 32: data width of all data ports.
REQ-003 Parameter MAX_WAIT, default 3: consecutive lost arbitrations after which fetch gains priority; legal range 1-15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_req  in  1  instruction-fetch read request.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_kill  in  1  discards any fetch response due next cycle (taken branch/flush).
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rdata  out  DW  fetch read data.
REQ-011 if_rvalid  out  1  if_rdata valid this cycle.
REQ-012 d_req  in  1  data-port request.
REQ-013 d_we  in  1  1 = write, 0 = read.
REQ-014 d_addr  in  AW  data address.
REQ-015 d_wdata  in  DW  write data.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rdata  out  DW  data read result.
REQ-018 d_rvalid  out  1  d_rdata valid this cycle; reads only.
REQ-019 mem_sel  out  1  shared address/data mux select; 1 = data port drives memory, 0 = fetch port.
REQ-020 mem_en  out  1  memory access strobe.
REQ-021 mem_we  out  1  memory write enable.
REQ-022 mem_addr  out  AW  memory address, muxed by mem_sel.
REQ-023 mem_wdata  out  DW  memory write data; always d_wdata.
REQ-024 mem_rdata  in  DW  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-025 Grants, mem_sel, mem_en, mem_we and mem_addr are combinational from current requests and registered state; at most one grant per cycle.
REQ-026 Arbitration: only one requester active -> that requester is granted; neither active -> no grant and mem_en=0.
REQ-027 Both requesting with wait_cnt < MAX_WAIT -> data granted; wait_cnt increments, saturating at 15.
REQ-028 Both requesting with wait_cnt >= MAX_WAIT -> fetch granted.
REQ-029 wait_cnt clears on any cycle with if_gnt=1 and on any cycle with if_req=0.
REQ-030 On grant: mem_en=1; mem_sel=1 for data and 0 for fetch; mem_we = d_we for data and 0 for fetch; mem_addr = granted address.
REQ-031 mem_sel holds its previous value when there is no grant (no glitching of the idle mux).
REQ-032 Registered response owner, state RSP_NONE/RSP_IF/RSP_D, updates each cycle: fetch grant -> RSP_IF; data read grant -> RSP_D; data write or no grant -> RSP_NONE.
REQ-033 Owner RSP_IF -> if_rvalid=1 and if_rdata=mem_rdata that cycle, unless if_kill was 1 in the grant cycle or is 1 in the response cycle; then if_rvalid=0.
REQ-034 Owner RSP_D -> d_rvalid=1 and d_rdata=mem_rdata.
REQ-035 if_rdata and d_rdata both carry mem_rdata unconditionally; only the rvalid signals qualify them.
REQ-036 Back-to-back accesses are allowed: a new grant may issue in the same cycle a response returns, giving throughput of one access per cycle.
REQ-037 A write completes at its grant cycle; no response is produced for a write.

Reset
REQ-038 When rst=1 at a clock edge: owner=RSP_NONE, wait_cnt=0, mem_sel=0, and if_rvalid=d_rvalid=0 in the following cycle.
REQ-039 While rst=1: if_gnt=d_gnt=mem_en=mem_we=0 regardless of requests; an access granted in the cycle before reset asserts yields no rvalid.

Verification
REQ-040 Fetch-only: if_req=1, addr 0x0,0x4,0x8 on consecutive cycles -> if_gnt=1 each cycle; if_rvalid=1 one cycle later with matching mem_rdata; mem_sel=0 throughout.
REQ-041 Contention, MAX_WAIT=3: if_req=d_req=1 held with reads -> grant pattern D,D,D,IF,D,D,D,IF; wait_cnt returns to 0 after each IF grant.
REQ-042 Data write 0xDEADBEEF at 0x100 -> mem_we=1, mem_sel=1, mem_wdata=0xDEADBEEF, d_gnt=1; no d_rvalid in the next cycle.
REQ-043 Kill: fetch granted at cycle t with if_kill=1 at t+1 -> if_rvalid=0 at t+1; a new fetch granted at t+1 returns normally at t+2.
REQ-044 Reset mid-operation: data read granted at t, rst=1 at t -> d_rvalid=0 at t+1; all grants 0 while rst=1; mem_sel=0 after reset.
REQ-045 Idle hold: data grant, then two idle cycles -> mem_en=0 and mem_sel stays 1 during the idle cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-cycle memory port between an instruction-fetch
//            port and a data port. Data wins contention until fetch has lost
//            MAX_WAIT times in a row. Read responses are steered back to the
//            owner one cycle after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    // instruction-fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_rvalid,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    // shared memory port
    output logic          mem_sel,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic [3:0] C_WAIT_SAT = 4'd15;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_t;

    rsp_t       r_owner;      // who receives mem_rdata this cycle
    logic [3:0] r_wait_cnt;   // consecutive arbitrations lost by fetch
    logic       r_sel;        // last driven mux select, held while idle
    logic       r_if_killed;  // outstanding fetch was killed in its grant cycle

    logic       w_if_gnt;
    logic       w_d_gnt;
    logic       w_sel;

    // Arbitration: single requester wins; on contention data wins until fetch starves
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                if (r_wait_cnt >= C_MAX_WAIT) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b1;
                end
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // Memory-side steering; the select keeps its old value when nobody is granted
    always_comb begin
        w_sel = r_sel;
        if (w_d_gnt) begin
            w_sel = 1'b1;
        end else if (w_if_gnt) begin
            w_sel = 1'b0;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_sel   = w_sel;
    assign mem_en    = w_if_gnt | w_d_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_addr  = w_sel ? d_addr : if_addr;
    assign mem_wdata = d_wdata;

    // Response owner, starvation counter, held select and kill tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= RSP_NONE;
            r_wait_cnt  <= 4'd0;
            r_sel       <= 1'b0;
            r_if_killed <= 1'b0;
        end else begin
            r_sel <= w_sel;

            if (w_if_gnt) begin
                r_owner <= RSP_IF;
            end else if (w_d_gnt && !d_we) begin
                r_owner <= RSP_D;
            end else begin
                r_owner <= RSP_NONE;
            end

            // A kill raised while an older fetch response is returning is spent
            // on that response; the fetch issued alongside it is the redirect
            // target and survives. With nothing returning, the kill targets the
            // fetch being granted now.
            r_if_killed <= if_kill && (r_owner != RSP_IF);

            if (w_if_gnt || !if_req) begin
                r_wait_cnt <= 4'd0;
            end else if (w_d_gnt && r_wait_cnt != C_WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // Read data is broadcast; only the valids qualify it. Reset suppresses a
    // response from an access granted just before reset asserted.
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_rvalid = !rst && (r_owner == RSP_IF) && !r_if_killed && !if_kill;
    assign d_rvalid  = !rst && (r_owner == RSP_D);

endmodule
`default_nettype wire
